// File: rtl/ppi_pkg.sv
// ppi_pkg: shared definitions for the 8255A-compatible PPI.
//   - a_state_e   : Port A Mode 1 handshake FSM states
//   - PC_*_A      : Port C bit indices used by Port A in Mode 1
//   - entry_state : FSM entry state for a given Mode1/DirOut configuration
package ppi_pkg;

    typedef enum logic [2:0] {
        StMode0,
        StInEmpty,
        StInFull,
        StOutEmpty,
        StOutFull
    } a_state_e;

    localparam logic [2:0] PC_INTR_A = 3'd3;
    localparam logic [2:0] PC_STB_A  = 3'd4;
    localparam logic [2:0] PC_IBF_A  = 3'd5;
    localparam logic [2:0] PC_ACK_A  = 3'd6;
    localparam logic [2:0] PC_OBF_A  = 3'd7;

    function automatic a_state_e entry_state(input logic mode1, input logic dir_out);
        if (!mode1) begin
            return StMode0;
        end else if (dir_out) begin
            return StOutEmpty;
        end else begin
            return StInEmpty;
        end
    endfunction

endpackage

// File: rtl/sync_edge.sv
// sync_edge: multi-flop synchronizer for an asynchronous active-low handshake pin, with
// registered single-cycle fall/rise pulses. All flops reset to the idle (high) level.
// Ports:
//   Clk, Reset_n  clock / asynchronous active-low reset
//   Din           asynchronous pin
//   Fall, Rise    one-cycle pulses, valid SYNC_STAGES+1 rising edges after the pin edge
module sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic Clk,
    input  logic Reset_n,
    input  logic Din,
    output logic Fall,
    output logic Rise
);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   last_q;
    logic                   fall_q, fall_d;
    logic                   rise_q, rise_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], Din};
        // Compare the synchronized level with its one-cycle-old copy.
        fall_d = last_q & ~sync_q[SYNC_STAGES-1];
        rise_d = ~last_q & sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q <= '1;
            last_q <= 1'b1;
            fall_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            last_q <= sync_q[SYNC_STAGES-1];
            fall_q <= fall_d;
            rise_q <= rise_d;
        end
    end

    assign Fall = fall_q;
    assign Rise = rise_q;

endmodule

// File: rtl/port_a_strobe_ctrl.sv
// port_a_strobe_ctrl: Port A Mode 1 (strobed I/O) handshake controller of the PPI.
// Ports:
//   Clk, Reset_n            clock / asynchronous active-low reset
//   Mode1, DirOut           configuration from Group A control (DirOut 1 = output)
//   CpuRd, CpuWr            one-cycle CPU access pulses for Port A
//   CpuDataIn, CpuDataOut   CPU write data / read data (input latch)
//   BsrWr, BsrBit, BsrVal   Port C bit set/reset command (drives INTE_A)
//   PortIn, PortOut, PortOe Port A pins: async input, output latch, output enable
//   Stb_n, Ack_n            PC4 strobe / PC6 acknowledge (asynchronous)
//   Ibf, Obf_n, Intr        PC5 / PC7 / PC3 handshake and interrupt outputs
module port_a_strobe_ctrl #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       Mode1,
    input  logic       DirOut,
    input  logic       CpuRd,
    input  logic       CpuWr,
    input  logic [7:0] CpuDataIn,
    output logic [7:0] CpuDataOut,
    input  logic       BsrWr,
    input  logic [2:0] BsrBit,
    input  logic       BsrVal,
    input  logic [7:0] PortIn,
    output logic [7:0] PortOut,
    output logic       PortOe,
    input  logic       Stb_n,
    input  logic       Ack_n,
    output logic       Ibf,
    output logic       Obf_n,
    output logic       Intr
);

    import ppi_pkg::*;

    logic stb_fall, stb_rise;
    logic ack_fall, ack_rise;

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_stb_sync (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .Din    (Stb_n),
        .Fall   (stb_fall),
        .Rise   (stb_rise)
    );

    sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_ack_sync (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .Din    (Ack_n),
        .Fall   (ack_fall),
        .Rise   (ack_rise)
    );

    // Plain synchronizer for the data pins.
    logic [7:0] port_sync_q [SYNC_STAGES];
    logic [7:0] port_sync;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                port_sync_q[i] <= 8'h00;
            end
        end else begin
            port_sync_q[0] <= PortIn;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                port_sync_q[i] <= port_sync_q[i-1];
            end
        end
    end

    assign port_sync = port_sync_q[SYNC_STAGES-1];

    a_state_e   state_q, state_d;
    logic       mode1_q, dir_q;
    logic       inte_q, inte_d;
    logic       ibf_q, ibf_d;
    logic       obf_n_q, obf_n_d;
    logic       intr_q, intr_d;
    logic [7:0] in_latch_q, in_latch_d;
    logic [7:0] out_latch_q, out_latch_d;
    logic       cfg_change;

    always_comb begin
        state_d     = state_q;
        inte_d      = inte_q;
        ibf_d       = ibf_q;
        obf_n_d     = obf_n_q;
        intr_d      = intr_q;
        in_latch_d  = in_latch_q;
        out_latch_d = out_latch_q;
        // mode1_q/dir_q hold the configuration the FSM was last operating in.
        cfg_change  = (Mode1 != mode1_q) || (DirOut != dir_q);

        if (cfg_change) begin
            // Re-enter the new configuration; data latches are deliberately kept.
            state_d = entry_state(Mode1, DirOut);
            inte_d  = 1'b0;
            ibf_d   = 1'b0;
            obf_n_d = 1'b1;
            intr_d  = 1'b0;
        end else begin
            if (BsrWr && (BsrBit == (DirOut ? PC_ACK_A : PC_STB_A))) begin
                inte_d = BsrVal;
            end

            case (state_q)
                StMode0: begin
                    in_latch_d = port_sync;
                    if (CpuWr) begin
                        out_latch_d = CpuDataIn;
                    end
                end

                StInEmpty, StInFull: begin
                    if (stb_rise && (state_q == StInFull) && inte_q) begin
                        intr_d = 1'b1;
                    end
                    if (stb_fall) begin
                        // Also covers overrun and a read coinciding with the strobe:
                        // the buffer stays full with the new data.
                        in_latch_d = port_sync;
                        ibf_d      = 1'b1;
                        state_d    = StInFull;
                        if (CpuRd) begin
                            intr_d = 1'b0;
                        end
                    end else if (CpuRd) begin
                        ibf_d   = 1'b0;
                        intr_d  = 1'b0;
                        state_d = StInEmpty;
                    end
                end

                StOutEmpty, StOutFull: begin
                    if (ack_rise && obf_n_q && inte_q) begin
                        intr_d = 1'b1;
                    end
                    if (CpuWr) begin
                        // A write wins over a coincident acknowledge.
                        out_latch_d = CpuDataIn;
                        obf_n_d     = 1'b0;
                        intr_d      = 1'b0;
                        state_d     = StOutFull;
                    end else if (ack_fall) begin
                        obf_n_d = 1'b1;
                        state_d = StOutEmpty;
                    end
                end

                default: begin
                    state_d = StMode0;
                end
            endcase
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q     <= StMode0;
            mode1_q     <= 1'b0;
            dir_q       <= 1'b0;
            inte_q      <= 1'b0;
            ibf_q       <= 1'b0;
            obf_n_q     <= 1'b1;
            intr_q      <= 1'b0;
            in_latch_q  <= 8'h00;
            out_latch_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            mode1_q     <= Mode1;
            dir_q       <= DirOut;
            inte_q      <= inte_d;
            ibf_q       <= ibf_d;
            obf_n_q     <= obf_n_d;
            intr_q      <= intr_d;
            in_latch_q  <= in_latch_d;
            out_latch_q <= out_latch_d;
        end
    end

    always_comb begin
        PortOe = 1'b0;
        unique case (state_q)
            StOutEmpty, StOutFull: PortOe = 1'b1;
            StMode0:               PortOe = dir_q;
            default:               PortOe = 1'b0;
        endcase
    end

    assign CpuDataOut = in_latch_q;
    assign PortOut    = out_latch_q;
    assign Ibf        = ibf_q;
    assign Obf_n      = obf_n_q;
    assign Intr       = intr_q;

endmodule

// File: tb/tb_port_a_strobe_ctrl.sv
module tb_port_a_strobe_ctrl;

    logic       Clk;
    logic       Reset_n;
    logic       Mode1, DirOut, CpuRd, CpuWr;
    logic [7:0] CpuDataIn, CpuDataOut;
    logic       BsrWr;
    logic [2:0] BsrBit;
    logic       BsrVal;
    logic [7:0] PortIn, PortOut;
    logic       PortOe, Stb_n, Ack_n, Ibf, Obf_n, Intr;

    int n_checks = 0;
    int n_fail   = 0;

    port_a_strobe_ctrl #(
        .SYNC_STAGES(2)
    ) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Mode1     (Mode1),
        .DirOut    (DirOut),
        .CpuRd     (CpuRd),
        .CpuWr     (CpuWr),
        .CpuDataIn (CpuDataIn),
        .CpuDataOut(CpuDataOut),
        .BsrWr     (BsrWr),
        .BsrBit    (BsrBit),
        .BsrVal    (BsrVal),
        .PortIn    (PortIn),
        .PortOut   (PortOut),
        .PortOe    (PortOe),
        .Stb_n     (Stb_n),
        .Ack_n     (Ack_n),
        .Ibf       (Ibf),
        .Obf_n     (Obf_n),
        .Intr      (Intr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic       mode1, dir_out, cpu_rd, cpu_wr;
        logic [7:0] data_in, port_in;
        logic       stb_n, ack_n, bsr_wr;
        logic [2:0] bsr_bit;
        logic       bsr_val;
        int         ncyc;
        logic [7:0] e_port_out;
        logic       e_oe;
        logic [7:0] e_data_out;
        logic       e_ibf, e_obf_n, e_intr;
    } vec_t;

    vec_t vecs[27];

    task automatic step(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    initial begin
        // mode dir rd wr din pin stb ack bw bit bv ncyc | pout oe dout ibf obf_n intr
        // Mode 0: input tracking latency, Stb_n ignored, CpuWr, PortOe follows DirOut
        vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,8'h5A,1'b1,1'b1,1'b0,3'd0,1'b0,2,
                     8'h00,1'b0,8'h00,1'b0,1'b1,1'b0};
        vecs[1]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,8'h5A,1'b1,1'b1,1'b0,3'd0,1'b0,1,
                     8'h00,1'b0,8'h5A,1'b0,1'b1,1'b0};
        vecs[2]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,8'h5A,1'b0,1'b1,1'b0,3'd0,1'b0,5,
                     8'h00,1'b0,8'h5A,1'b0,1'b1,1'b0};
        vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,8'h00,8'h5A,1'b1,1'b1,1'b0,3'd0,1'b0,5,
                     8'h00,1'b0,8'h5A,1'b0,1'b1,1'b0};
        vecs[4]  = '{1'b0,1'b0,1'b0,1'b1,8'h77,8'h5A,1'b1,1'b1,1'b0,3'd0,1'b0,1,
                     8'h77,1'b0,8'h5A,1'b0,1'b1,1'b0};
        vecs[5]  = '{1'b0,1'b1,1'b0,1'b0,8'h00,8'h5A,1'b1,1'b1,1'b0,3'd0,1'b0,1,
                     8'h77,1'b1,8'h5A,1'b0,1'b1,1'b0};
        // Mode 1 output handshake with INTE_A=1
        vecs[6]  = '{1'b1,1'b1,1'b0,1'b0,8'h00,8'h5A,1'b1,1'b1,1'b0,3'd0,1'b0,1,
                     8'h77,1'b1,8'h5A,1'b0,1'b1,1'b0};
        vecs[7]  = '{1'b1,1'b1,1'b0,1'b0,8'h00,8'h5A,1'b1,1'b1,1'b1,3'd6,1'b1,1,
                     8'h77,1'b1,8'h5A,1'b0,1'b1,1'b0};
        vecs[8]  = '{1'b1,1'b1,1'b0,1'b1,8'h3C,8'h5A,1'b1,1'b1,1'b0,3'd0,1'b0,1,
                     8'h3C,1'b1,8'h5A,1'b0,1'b0,1'b0};
        vecs[9]  = '{1'b1,1'b1,1'b0,1'b0,8'h00,8'h5A,1'b1,1'b0,1'b0,3'd0,1'b0,3,
                     8'h3C,1'b1,8'h5A,1'b0,1'b0,1'b0};
        vecs[10] = '{1'b1,1'b1,1'b0,1'b0,8'h00,8'h5A,1'b1,1'b0,1'b0,3'd0,1'b0,1,
                     8'h3C,1'b1,8'h5A,1'b0,1'b1,1'b0};
        vecs[11] = '{1'b1,1'b1,1'b0,1'b0,8'h00,8'h5A,1'b1,1'b1,1'b0,3'd0,1'b0,3,
                     8'h3C,1'b1,8'h5A,1'b0,1'b1,1'b0};
        vecs[12] = '{1'b1,1'b1,1'b0,1'b0,8'h00,8'h5A,1'b1,1'b1,1'b0,3'd0,1'b0,1,
                     8'h3C,1'b1,8'h5A,1'b0,1'b1,1'b1};
        vecs[13] = '{1'b1,1'b1,1'b0,1'b1,8'h96,8'h5A,1'b1,1'b1,1'b0,3'd0,1'b0,1,
                     8'h96,1'b1,8'h5A,1'b0,1'b0,1'b0};
        vecs[14] = '{1'b1,1'b1,1'b0,1'b1,8'h69,8'h5A,1'b1,1'b1,1'b0,3'd0,1'b0,1,
                     8'h69,1'b1,8'h5A,1'b0,1'b0,1'b0};
        vecs[15] = '{1'b1,1'b1,1'b1,1'b0,8'h00,8'h5A,1'b1,1'b1,1'b0,3'd0,1'b0,1,
                     8'h69,1'b1,8'h5A,1'b0,1'b0,1'b0};
        // INTE_A cleared via bit 6; bit 4 must be ignored while in output mode
        vecs[16] = '{1'b1,1'b1,1'b0,1'b0,8'h00,8'h5A,1'b1,1'b1,1'b1,3'd6,1'b0,1,
                     8'h69,1'b1,8'h5A,1'b0,1'b0,1'b0};
        vecs[17] = '{1'b1,1'b1,1'b0,1'b0,8'h00,8'h5A,1'b1,1'b1,1'b1,3'd4,1'b1,1,
                     8'h69,1'b1,8'h5A,1'b0,1'b0,1'b0};
        vecs[18] = '{1'b1,1'b1,1'b0,1'b0,8'h00,8'h5A,1'b1,1'b0,1'b0,3'd0,1'b0,4,
                     8'h69,1'b1,8'h5A,1'b0,1'b1,1'b0};
        vecs[19] = '{1'b1,1'b1,1'b0,1'b0,8'h00,8'h5A,1'b1,1'b1,1'b0,3'd0,1'b0,4,
                     8'h69,1'b1,8'h5A,1'b0,1'b1,1'b0};
        // Mode 1 input handshake with INTE_A=1
        vecs[20] = '{1'b1,1'b0,1'b0,1'b0,8'h00,8'hA5,1'b1,1'b1,1'b0,3'd0,1'b0,1,
                     8'h69,1'b0,8'h5A,1'b0,1'b1,1'b0};
        vecs[21] = '{1'b1,1'b0,1'b0,1'b0,8'h00,8'hA5,1'b1,1'b1,1'b1,3'd4,1'b1,1,
                     8'h69,1'b0,8'h5A,1'b0,1'b1,1'b0};
        vecs[22] = '{1'b1,1'b0,1'b0,1'b0,8'h00,8'hA5,1'b0,1'b1,1'b0,3'd0,1'b0,3,
                     8'h69,1'b0,8'h5A,1'b0,1'b1,1'b0};
        vecs[23] = '{1'b1,1'b0,1'b0,1'b0,8'h00,8'hA5,1'b0,1'b1,1'b0,3'd0,1'b0,1,
                     8'h69,1'b0,8'hA5,1'b1,1'b1,1'b0};
        vecs[24] = '{1'b1,1'b0,1'b0,1'b0,8'h00,8'hA5,1'b1,1'b1,1'b0,3'd0,1'b0,4,
                     8'h69,1'b0,8'hA5,1'b1,1'b1,1'b1};
        vecs[25] = '{1'b1,1'b0,1'b0,1'b1,8'hFF,8'hA5,1'b1,1'b1,1'b0,3'd0,1'b0,1,
                     8'h69,1'b0,8'hA5,1'b1,1'b1,1'b1};
        vecs[26] = '{1'b1,1'b0,1'b1,1'b0,8'h00,8'hA5,1'b1,1'b1,1'b0,3'd0,1'b0,1,
                     8'h69,1'b0,8'hA5,1'b0,1'b1,1'b0};

        // Reset state
        Reset_n = 1'b0;
        Mode1 = 1'b0; DirOut = 1'b0; CpuRd = 1'b0; CpuWr = 1'b0; CpuDataIn = 8'h00;
        BsrWr = 1'b0; BsrBit = 3'd0; BsrVal = 1'b0; PortIn = 8'h00;
        Stb_n = 1'b1; Ack_n = 1'b1;
        step(2);
        chk8("rst port_out", PortOut, 8'h00);
        chk1("rst port_oe", PortOe, 1'b0);
        chk8("rst data_out", CpuDataOut, 8'h00);
        chk1("rst ibf", Ibf, 1'b0);
        chk1("rst obf_n", Obf_n, 1'b1);
        chk1("rst intr", Intr, 1'b0);
        Reset_n = 1'b1;
        step(1);

        foreach (vecs[i]) begin
            Mode1 = vecs[i].mode1; DirOut = vecs[i].dir_out;
            CpuRd = vecs[i].cpu_rd; CpuWr = vecs[i].cpu_wr; CpuDataIn = vecs[i].data_in;
            PortIn = vecs[i].port_in; Stb_n = vecs[i].stb_n; Ack_n = vecs[i].ack_n;
            BsrWr = vecs[i].bsr_wr; BsrBit = vecs[i].bsr_bit; BsrVal = vecs[i].bsr_val;
            step(1);
            CpuRd = 1'b0; CpuWr = 1'b0; BsrWr = 1'b0;
            step(vecs[i].ncyc - 1);
            chk8($sformatf("v%0d port_out", i), PortOut, vecs[i].e_port_out);
            chk1($sformatf("v%0d port_oe", i), PortOe, vecs[i].e_oe);
            chk8($sformatf("v%0d data_out", i), CpuDataOut, vecs[i].e_data_out);
            chk1($sformatf("v%0d ibf", i), Ibf, vecs[i].e_ibf);
            chk1($sformatf("v%0d obf_n", i), Obf_n, vecs[i].e_obf_n);
            chk1($sformatf("v%0d intr", i), Intr, vecs[i].e_intr);
        end

        // Input: read coincident with strobe fall (old=0x11, new=0x22)
        PortIn = 8'h11; Stb_n = 1'b0; step(4);
        Stb_n = 1'b1; step(4);
        chk8("coin_in first data", CpuDataOut, 8'h11);
        chk1("coin_in first intr", Intr, 1'b1);
        PortIn = 8'h22; Stb_n = 1'b0; step(3);
        CpuRd = 1'b1; #1;
        chk8("coin_in read old", CpuDataOut, 8'h11);
        step(1); CpuRd = 1'b0;
        chk1("coin_in ibf", Ibf, 1'b1);
        chk1("coin_in intr", Intr, 1'b0);
        chk8("coin_in new latched", CpuDataOut, 8'h22);
        Stb_n = 1'b1; step(4);
        chk1("coin_in intr2", Intr, 1'b1);
        CpuRd = 1'b1; #1;
        chk8("coin_in read new", CpuDataOut, 8'h22);
        step(1); CpuRd = 1'b0;
        chk1("coin_in ibf clr", Ibf, 1'b0);

        // Output: write coincident with acknowledge fall
        DirOut = 1'b1; step(1);
        chk1("coin_out entry obf_n", Obf_n, 1'b1);
        CpuWr = 1'b1; CpuDataIn = 8'h3C; step(1); CpuWr = 1'b0;
        chk1("coin_out wr obf_n", Obf_n, 1'b0);
        Ack_n = 1'b0; step(3);
        CpuWr = 1'b1; CpuDataIn = 8'hC3; step(1); CpuWr = 1'b0;
        chk1("coin_out obf_n", Obf_n, 1'b0);
        chk8("coin_out port_out", PortOut, 8'hC3);
        step(3);
        Ack_n = 1'b1; step(4);
        chk1("coin_out obf_n held", Obf_n, 1'b0);
        chk1("coin_out intr", Intr, 1'b0);

        // Mode change from IN_FULL with Intr=1 to output
        DirOut = 1'b0; step(1);
        BsrWr = 1'b1; BsrBit = 3'd4; BsrVal = 1'b1; step(1); BsrWr = 1'b0;
        PortIn = 8'h44; Stb_n = 1'b0; step(4);
        Stb_n = 1'b1; step(4);
        chk1("mc pre ibf", Ibf, 1'b1);
        chk1("mc pre intr", Intr, 1'b1);
        DirOut = 1'b1; step(1);
        chk1("mc ibf", Ibf, 1'b0);
        chk1("mc intr", Intr, 1'b0);
        chk1("mc obf_n", Obf_n, 1'b1);
        chk1("mc port_oe", PortOe, 1'b1);
        chk8("mc latch kept", CpuDataOut, 8'h44);
        Ack_n = 1'b0; step(4);
        Ack_n = 1'b1; step(4);
        chk1("mc inte cleared", Intr, 1'b0);

        // Asynchronous reset in OUT_FULL
        CpuWr = 1'b1; CpuDataIn = 8'h5B; step(1); CpuWr = 1'b0;
        chk1("ar pre obf_n", Obf_n, 1'b0);
        chk8("ar pre port_out", PortOut, 8'h5B);
        #3 Reset_n = 1'b0;
        #1;
        chk8("ar port_out", PortOut, 8'h00);
        chk1("ar obf_n", Obf_n, 1'b1);
        chk1("ar port_oe", PortOe, 1'b0);
        chk1("ar intr", Intr, 1'b0);
        chk8("ar data_out", CpuDataOut, 8'h00);
        step(2);
        Reset_n = 1'b1;
        step(1);
        chk1("ar release port_oe", PortOe, 1'b1);
        chk1("ar release obf_n", Obf_n, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
